// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-RAM access unit: op codes, FSM states,
// lane ordering and request classification.
package mem_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    // Memory lane k holds byte offset k, so CPU order is the byte-reversed raw word
    function automatic logic [31:0] byte_reverse(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic is_subword_store(input mem_op_t op);
        return (op == SH) || (op == SB);
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] offset);
        logic half_op;
        logic word_op;
        half_op = (op == LH) || (op == LHU) || (op == SH);
        word_op = (op == LW) || (op == SW);
        return (half_op && offset[0]) || (word_op && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Lane steering between the raw memory word and CPU values: load extraction
// with sign/zero extension and read-modify-write merge for sub-word stores.
module mem_lane_merge
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw,
    input  mem_op_t           op,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] store_word
);

    function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] v);
        return DATA_W'(v);
    endfunction

    logic [7:0]  lane      [4];
    logic [7:0]  mlane     [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [1:0]  hi_idx;
    logic [1:0]  lo_idx;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane[k] = raw[8*k +: 8];
        end
    end

    // Halfwords are always even-aligned here, so offset[1] picks the lane pair
    assign hi_idx   = {offset[1], 1'b0};
    assign lo_idx   = {offset[1], 1'b1};
    assign byte_sel = lane[offset];
    assign half_sel = {lane[hi_idx], lane[lo_idx]};

    always_comb begin
        load_val = '0;
        case (op)
            LW:      load_val = byte_reverse(raw);
            LH:      load_val = sext16(half_sel);
            LHU:     load_val = {{(DATA_W-16){1'b0}}, half_sel};
            LB:      load_val = sext8(byte_sel);
            LBU:     load_val = {{(DATA_W-8){1'b0}}, byte_sel};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mlane[k] = lane[k];
        end
        case (op)
            SB: mlane[offset] = wdata[7:0];
            SH: begin
                mlane[hi_idx] = wdata[15:8];
                mlane[lo_idx] = wdata[7:0];
            end
            default: ;
        endcase
        if (op == SW) begin
            store_word = byte_reverse(wdata);
        end else begin
            store_word = {mlane[3], mlane[2], mlane[1], mlane[0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the single-port data RAM: one request at a time,
// big-endian CPU view over byte-swapped memory words, RMW for sub-word stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  mem_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_read,
    output logic              data_write,
    output logic [DATA_W-1:0] data_writedata,
    input  logic [DATA_W-1:0] data_readdata
);

    mem_state_t        state;
    mem_op_t           op_p0;
    logic [1:0]        off_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;

    assign req_ready = (state == IDLE);

    mem_lane_merge #(.DATA_W(DATA_W)) u_lane_merge (
        .raw        (data_readdata),
        .op         (op_p0),
        .offset     (off_p0),
        .wdata      (wdata_p0),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op_p0          <= LW;
            off_p0         <= '0;
            wdata_p0       <= '0;
            data_read      <= 1'b0;
            data_write     <= 1'b0;
            data_address   <= '0;
            data_writedata <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
        end else begin
            data_read  <= 1'b0;
            data_write <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                // Accept: strobes are registered, so they are set up for the next state here
                IDLE: begin
                    if (req_valid) begin
                        op_p0    <= req_op;
                        off_p0   <= req_addr[1:0];
                        wdata_p0 <= req_wdata;
                        if (misaligned(req_op, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_op == SW) begin
                            state          <= WR;
                            data_write     <= 1'b1;
                            data_address   <= {req_addr[ADDR_W-1:2], 2'b00};
                            data_writedata <= byte_reverse(req_wdata);
                        end else begin
                            state        <= RD;
                            data_read    <= 1'b1;
                            data_address <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                // Raw word is consumed straight off the combinational RAM read at the end of RD
                RD: begin
                    if (is_subword_store(op_p0)) begin
                        state          <= WR;
                        data_write     <= 1'b1;
                        data_writedata <= store_word;
                    end else begin
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_err     <= 1'b0;
                        resp_rdata   <= load_val;
                        data_address <= '0;
                    end
                end
                WR: begin
                    state        <= RESP;
                    resp_valid   <= 1'b1;
                    resp_err     <= 1'b0;
                    data_address <= '0;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random loads/stores against a
// byte-array memory model, with a word RAM model attached to the data port.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    mem_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] init_w [16];
    logic        ram_init;
    logic [31:0] ram [16];
    logic [7:0]  ref_b [64];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    assign data_readdata = ram[data_address[5:2]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_w[i];
        end else if (data_write) begin
            ram[data_address[5:2]] <= data_writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_misaligned(input mem_op_t op, input logic [31:0] a);
        case (op)
            LW, SW:      return a[1:0] != 2'b00;
            LH, LHU, SH: return a[0];
            default:     return 1'b0;
        endcase
    endfunction

    // Big-endian CPU view of the byte array
    function automatic logic [31:0] ref_load(input mem_op_t op, input logic [31:0] a);
        logic [15:0] h;
        logic [7:0]  b;
        h = {ref_b[a[5:0]], ref_b[a[5:0] + 6'd1]};
        b = ref_b[a[5:0]];
        case (op)
            LW:      return {ref_b[a[5:0]], ref_b[a[5:0] + 6'd1], ref_b[a[5:0] + 6'd2], ref_b[a[5:0] + 6'd3]};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
        case (op)
            SW: for (int i = 0; i < 4; i++) ref_b[a[5:0] + 6'(i)] = d[31-8*i -: 8];
            SH: begin
                ref_b[a[5:0]]        = d[15:8];
                ref_b[a[5:0] + 6'd1] = d[7:0];
            end
            SB: ref_b[a[5:0]] = d[7:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] ref_raw_word(input logic [31:0] a);
        logic [5:0] base;
        base = {a[5:2], 2'b00};
        return {ref_b[base + 6'd3], ref_b[base + 6'd2], ref_b[base + 6'd1], ref_b[base]};
    endfunction

    task automatic do_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata);
        logic        err, ld, st, sub;
        int          exp_lat, lat, rd_n, wr_n, rd_at, wr_at;
        logic        done;
        logic [31:0] exp_rd, got_rd, wr_word, wr_addr, rd_addr;
        logic        got_err, both;
        err = ref_misaligned(op, addr);
        ld  = (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
        st  = !ld;
        sub = (op == SH) || (op == SB);
        exp_lat = err ? 1 : (sub ? 3 : 2);
        exp_rd  = ref_load(op, addr);

        @(negedge clk);
        check("ready_idle", {31'h0, req_ready}, 32'h1);
        check("resp_pulse", {31'h0, resp_valid}, 32'h0);
        check("addr_idle", data_address, 32'h0);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; done = 1'b0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0; both = 1'b0;
        wr_word = '0; wr_addr = '0; rd_addr = '0; got_rd = '0; got_err = 1'b0;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            if (data_read)  begin rd_n++; rd_at = lat; rd_addr = data_address; end
            if (data_write) begin wr_n++; wr_at = lat; wr_word = data_writedata; wr_addr = data_address; end
            if (data_read && data_write) both = 1'b1;
            if (resp_valid) begin done = 1'b1; got_rd = resp_rdata; got_err = resp_err; end
        end

        if (st && !err) ref_store(op, addr, wdata);

        check("latency", done ? lat : 99, exp_lat);
        check("resp_err", {31'h0, got_err}, {31'h0, err});
        check("rd_wr_excl", {31'h0, both}, 32'h0);
        check("rd_count", rd_n, (err || op == SW) ? 0 : 1);
        check("wr_count", wr_n, (st && !err) ? 1 : 0);
        if (rd_n > 0) begin
            check("rd_cycle", rd_at, 1);
            check("rd_addr", rd_addr, {addr[31:2], 2'b00});
        end
        if (wr_n > 0) begin
            check("wr_cycle", wr_at, sub ? 2 : 1);
            check("wr_addr", wr_addr, {addr[31:2], 2'b00});
            check("wr_data", wr_word, ref_raw_word(addr));
        end
        if (ld && !err) check("rdata", got_rd, exp_rd);
    endtask

    task automatic reset_abort_sb(input logic [31:0] addr);
        logic wr_seen, resp_seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = SB; req_addr = addr; req_wdata = 32'h0000_005A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_rd", {31'h0, data_read}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wr_seen = 1'b0; resp_seen = 1'b0;
        @(negedge clk);
        check("abort_idle", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (data_write) wr_seen = 1'b1;
            if (resp_valid) resp_seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_write", {31'h0, wr_seen}, 32'h0);
        check("abort_no_resp", {31'h0, resp_seen}, 32'h0);
    endtask

    initial begin
        mem_op_t op;
        reset = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = '0; req_wdata = '0;
        init_w[0] = 32'h7856_3412;
        init_w[1] = 32'hAC68_EEEE;
        for (int i = 2; i < 16; i++) init_w[i] = $urandom;
        for (int w = 0; w < 16; w++)
            for (int k = 0; k < 4; k++) ref_b[4*w + k] = init_w[w][8*k +: 8];
        ram_init = 1'b1;
        repeat (2) @(posedge clk);
        #1 ram_init = 1'b0;
        reset = 1'b0;

        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp", {29'h0, resp_valid, resp_err, data_read}, 32'h0);
        check("rst_write", {31'h0, data_write}, 32'h0);
        check("rst_addr", data_address, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_wdata", data_writedata, 32'h0);

        do_req(LW,  32'h0, 32'h0);
        do_req(LB,  32'h4, 32'h0);
        do_req(LBU, 32'h4, 32'h0);
        do_req(LB,  32'h3, 32'h0);
        do_req(LH,  32'h6, 32'h0);
        do_req(SB,  32'h1, 32'h0000_00AB);
        do_req(LW,  32'h0, 32'h0);
        check("sb_result", ref_load(LW, 32'h0), 32'h12AB_5678);
        do_req(SW,  32'h8, 32'hCAFE_F00D);
        do_req(LW,  32'h8, 32'h0);
        do_req(LW,  32'h2, 32'h0);
        do_req(SH,  32'h5, 32'h1234);
        do_req(SH,  32'h6, 32'hBEEF);
        do_req(LHU, 32'h6, 32'h0);

        reset_abort_sb(32'h0);
        do_req(LW, 32'h0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            op = mem_op_t'($urandom_range(0, 7));
            do_req(op, 32'($urandom_range(0, 63)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
